// File: rtl/dcache_replace_arbiter_pkg.sv
// Shared types for the D-cache replacer arbiter: replacer commands, arbiter
// state encoding for trace decode, and the legal-command helper.
package dcache_replace_arbiter_pkg;

  localparam int CMD_W = 2;

  typedef enum logic [1:0] {
    CMD_WRITE_THROUGH = 2'd0,
    CMD_REPLACE       = 2'd1,
    CMD_INVALIDATE    = 2'd2,
    CMD_RESERVED      = 2'd3
  } ReplaceLogicCommand;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ISSUE  = 2'd1,
    ARB_WAIT   = 2'd2,
    ARB_REJECT = 2'd3
  } ReplaceArbiterState;

  function automatic logic is_legal_cmd(input logic [CMD_W-1:0] cmd);
    case (cmd)
      CMD_WRITE_THROUGH,
      CMD_REPLACE,
      CMD_INVALIDATE: return 1'b1;
      default:        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dcache_rr_picker.sv
// Combinational round-robin picker: first valid requester at or after rrPtr,
// found by scanning a doubled copy of the request vector.
module dcache_rr_picker #(
  parameter int N_REQ = 3,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] reqValid,
  input  logic [IDX_W-1:0] rrPtr,
  output logic [IDX_W-1:0] winner,
  output logic             anyValid
);

  logic [2*N_REQ-1:0] w_dbl;
  logic [IDX_W:0]     w_pos;
  logic               w_found;

  assign w_dbl    = {reqValid, reqValid};
  assign anyValid = |reqValid;

  // Lowest offset from rrPtr wins; positions past N_REQ fold back onto the low copy.
  always_comb begin
    winner  = '0;
    w_found = 1'b0;
    w_pos   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_pos = {1'b0, rrPtr} + (IDX_W+1)'(i);
      if (!w_found && w_dbl[w_pos]) begin
        w_found = 1'b1;
        if (w_pos >= (IDX_W+1)'(N_REQ)) begin
          winner = IDX_W'(w_pos - (IDX_W+1)'(N_REQ));
        end else begin
          winner = IDX_W'(w_pos);
        end
      end else begin
        w_found = w_found;
      end
    end
  end

endmodule

// File: rtl/dcache_replace_arbiter.sv
// Round-robin arbiter sharing one D-cache replacer between several requesters;
// latches the owner's command/address and returns a one-cycle done pulse.
module dcache_replace_arbiter
  import dcache_replace_arbiter_pkg::*;
#(
  parameter int N_REQ          = 3,
  parameter int MEM_ADDR_WIDTH = 26
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_REQ-1:0]                  reqValid,
  input  logic [N_REQ*CMD_W-1:0]            reqCommand,
  input  logic [N_REQ*MEM_ADDR_WIDTH-1:0]   reqAddr,
  output logic [N_REQ-1:0]                  reqGrant,
  output logic [N_REQ-1:0]                  reqDone,
  output logic                              replacerEnable,
  output logic [CMD_W-1:0]                  replacerCommand,
  output logic [MEM_ADDR_WIDTH-1:0]         replacerAddr,
  input  logic                              replacerDone,
  output logic                              busy,
  output logic                              illegalCommand
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  ReplaceArbiterState        r_state, w_next;
  logic [IDX_W-1:0]          r_owner, r_rr_ptr, w_winner, w_owner_inc;
  logic [CMD_W-1:0]          r_cmd, w_win_cmd;
  logic [MEM_ADDR_WIDTH-1:0] r_addr, w_win_addr;
  logic [N_REQ-1:0]          w_owner_onehot;
  logic                      r_illegal, w_any, w_finish;

  dcache_rr_picker #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_picker (
    .reqValid (reqValid),
    .rrPtr    (r_rr_ptr),
    .winner   (w_winner),
    .anyValid (w_any)
  );

  assign w_win_cmd      = reqCommand[int'(w_winner)*CMD_W +: CMD_W];
  assign w_win_addr     = reqAddr[int'(w_winner)*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
  assign w_owner_inc    = (r_owner == IDX_W'(N_REQ-1)) ? '0 : r_owner + IDX_W'(1);
  assign w_owner_onehot = N_REQ'(1) << r_owner;

  // Next-state decode; w_finish marks the cycle the owner's operation ends.
  always_comb begin
    w_next   = r_state;
    w_finish = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_any) begin
          w_next = is_legal_cmd(w_win_cmd) ? ARB_ISSUE : ARB_REJECT;
        end else begin
          w_next = ARB_IDLE;
        end
      end
      ARB_ISSUE: w_next = ARB_WAIT;
      ARB_WAIT: begin
        if (replacerDone) begin
          w_finish = 1'b1;
          w_next   = ARB_IDLE;
        end else begin
          w_next = ARB_WAIT;
        end
      end
      ARB_REJECT: begin
        w_finish = 1'b1;
        w_next   = ARB_IDLE;
      end
      default: w_next = ARB_IDLE;
    endcase
  end

  // State, owner latches, round-robin pointer and sticky illegal flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ARB_IDLE;
      r_owner   <= '0;
      r_rr_ptr  <= '0;
      r_cmd     <= '0;
      r_addr    <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ARB_IDLE && w_any) begin
        r_owner <= w_winner;
        r_cmd   <= w_win_cmd;
        r_addr  <= w_win_addr;
      end
      if (w_finish) begin
        r_rr_ptr <= w_owner_inc;
      end
      if (r_state == ARB_REJECT) begin
        r_illegal <= 1'b1;
      end
    end
  end

  assign busy            = (r_state != ARB_IDLE);
  assign replacerEnable  = (r_state == ARB_ISSUE);
  assign replacerCommand = r_cmd;
  assign replacerAddr    = r_addr;
  assign reqGrant        = busy ? w_owner_onehot : '0;
  assign reqDone         = w_finish ? w_owner_onehot : '0;
  assign illegalCommand  = r_illegal;

endmodule

// File: tb/tb_dcache_replace_arbiter.sv
// Directed self-checking bench for dcache_replace_arbiter (N_REQ=3).
module tb_dcache_replace_arbiter;

  localparam int AW = 26;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [2:0]    reqValid = 3'b000;
  logic [5:0]    reqCommand = 6'd0;
  logic [3*AW-1:0] reqAddr = '0;
  logic [2:0]    reqGrant, reqDone;
  logic          replacerEnable, replacerDone = 1'b0;
  logic [1:0]    replacerCommand;
  logic [AW-1:0] replacerAddr;
  logic          busy, illegalCommand;

  int checks = 0;
  int errors = 0;

  dcache_replace_arbiter #(.N_REQ(3), .MEM_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .reqValid(reqValid), .reqCommand(reqCommand),
    .reqAddr(reqAddr), .reqGrant(reqGrant), .reqDone(reqDone),
    .replacerEnable(replacerEnable), .replacerCommand(replacerCommand),
    .replacerAddr(replacerAddr), .replacerDone(replacerDone),
    .busy(busy), .illegalCommand(illegalCommand)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One Replace-style operation: Issue next cycle, done lat cycles after enable.
  task automatic serve(input string tag, input logic [2:0] g, input int lat);
    tick();
    chk({tag, "_en"}, 32'(replacerEnable), 32'd1);
    chk({tag, "_grant"}, 32'(reqGrant), 32'(g));
    for (int i = 1; i < lat; i++) begin
      tick();
      chk({tag, "_wait_en"}, 32'(replacerEnable), 32'd0);
    end
    tick();
    replacerDone = 1'b1;
    #1;
    chk({tag, "_done"}, 32'(reqDone), 32'(g));
    tick();
    replacerDone = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_grant", 32'(reqGrant), 32'd0);
    chk("rst_done", 32'(reqDone), 32'd0);
    chk("rst_en", 32'(replacerEnable), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_illegal", 32'(illegalCommand), 32'd0);
    chk("rst_addr", 32'(replacerAddr), 32'd0);
    rst = 1'b1;
    tick();

    // Single Invalidate from requester 0
    reqCommand = {2'd0, 2'd0, 2'd2};
    reqAddr    = {26'd0, 26'd0, 26'h0000123};
    reqValid   = 3'b001;
    #1;
    chk("inv_T_busy", 32'(busy), 32'd0);
    tick();
    chk("inv_T1_en", 32'(replacerEnable), 32'd1);
    chk("inv_T1_grant", 32'(reqGrant), 32'b001);
    chk("inv_T1_addr", 32'(replacerAddr), 32'h123);
    chk("inv_T1_cmd", 32'(replacerCommand), 32'd2);
    chk("inv_T1_done", 32'(reqDone), 32'd0);
    tick();
    chk("inv_T2_en", 32'(replacerEnable), 32'd0);
    replacerDone = 1'b1;
    reqValid     = 3'b000;
    #1;
    chk("inv_T2_done", 32'(reqDone), 32'b001);
    chk("inv_T2_addr", 32'(replacerAddr), 32'h123);
    tick();
    replacerDone = 1'b0;
    #1;
    chk("inv_T3_busy", 32'(busy), 32'd0);
    chk("inv_T3_done", 32'(reqDone), 32'd0);

    // Address stability: requester 1 WriteThrough at 0x1 (rrPtr now 1)
    reqCommand = {2'd0, 2'd0, 2'd0};
    reqAddr    = {26'd0, 26'h1, 26'd0};
    reqValid   = 3'b010;
    tick();
    chk("adr_en", 32'(replacerEnable), 32'd1);
    chk("adr_grant", 32'(reqGrant), 32'b010);
    chk("adr_cmd", 32'(replacerCommand), 32'd0);
    tick();
    reqAddr = {26'd0, 26'h2, 26'd0};
    #1;
    chk("adr_wait1", 32'(replacerAddr), 32'h1);
    tick();
    chk("adr_wait2", 32'(replacerAddr), 32'h1);
    tick();
    replacerDone = 1'b1;
    #1;
    chk("adr_done", 32'(reqDone), 32'b010);
    chk("adr_done_addr", 32'(replacerAddr), 32'h1);
    reqValid = 3'b000;
    tick();
    replacerDone = 1'b0;
    #1;
    chk("adr_idle", 32'(busy), 32'd0);

    // Illegal command from requester 2 (rrPtr now 2)
    reqCommand = {2'd3, 2'd0, 2'd0};
    reqValid   = 3'b100;
    tick();
    chk("ill_done", 32'(reqDone), 32'b100);
    chk("ill_grant", 32'(reqGrant), 32'b100);
    chk("ill_en", 32'(replacerEnable), 32'd0);
    reqValid = 3'b000;
    tick();
    chk("ill_sticky", 32'(illegalCommand), 32'd1);
    chk("ill_en2", 32'(replacerEnable), 32'd0);
    chk("ill_idle", 32'(busy), 32'd0);

    // Round-robin: all valid with Replace, rrPtr wrapped to 0
    reqCommand = {2'd1, 2'd1, 2'd1};
    reqAddr    = {26'h30, 26'h20, 26'h10};
    reqValid   = 3'b111;
    serve("rr0", 3'b001, 5);
    serve("rr1", 3'b010, 5);
    serve("rr2", 3'b100, 5);
    serve("rr3", 3'b001, 5);
    chk("rr_sticky", 32'(illegalCommand), 32'd1);

    // Reset mid-Wait: requester 1 is granted next (rrPtr 1)
    tick();
    chk("rw_grant", 32'(reqGrant), 32'b010);
    tick();
    rst      = 1'b0;
    reqValid = 3'b000;
    tick();
    chk("rw_grant0", 32'(reqGrant), 32'd0);
    chk("rw_done0", 32'(reqDone), 32'd0);
    chk("rw_busy0", 32'(busy), 32'd0);
    chk("rw_en0", 32'(replacerEnable), 32'd0);
    chk("rw_ill0", 32'(illegalCommand), 32'd0);
    rst          = 1'b1;
    replacerDone = 1'b1;
    #1;
    chk("rw_spur_done", 32'(reqDone), 32'd0);
    tick();
    replacerDone = 1'b0;
    #1;
    chk("rw_spur_busy", 32'(busy), 32'd0);

    // Drop-valid: requesters 0 and 1 valid; rrPtr reset so 0 wins
    reqValid = 3'b011;
    tick();
    chk("dv_grant", 32'(reqGrant), 32'b001);
    tick();
    reqValid = 3'b010;
    tick();
    tick();
    replacerDone = 1'b1;
    #1;
    chk("dv_done", 32'(reqDone), 32'b001);
    tick();
    replacerDone = 1'b0;
    tick();
    chk("dv_next_grant", 32'(reqGrant), 32'b010);
    tick();
    replacerDone = 1'b1;
    #1;
    chk("dv_next_done", 32'(reqDone), 32'b010);
    reqValid = 3'b000;
    tick();
    replacerDone = 1'b0;
    #1;
    chk("dv_end_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_replace_arbiter.md
# dcache_replace_arbiter

Shares the single D-cache replacer (line write-through, replace and invalidate engine) between several requesters: load-miss, store write-through and fence/invalidate logic. Grants requests round-robin, holds the owner's command and address stable for the whole operation, and returns a one-cycle completion pulse to the owner. Sits between the D-cache pipeline stages and the replacer's enable/command/commandAddr/done port.

## Interface
Parameters:
- N_REQ, default 3: number of requesters (2..8).
- MEM_ADDR_WIDTH, default 26: line address width (tag + index).

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Synchronous, active-low: low at a clk edge resets the block.
- reqValid  in  N_REQ  per-requester request. Held high until that requester's reqDone.
- reqCommand  in  N_REQ x ReplaceLogicCommand  per-requester command.
- reqAddr  in  N_REQ x MEM_ADDR_WIDTH  per-requester line address.
- reqGrant  out  N_REQ  one-hot owner of the replacer. Zero when idle.
- reqDone  out  N_REQ  one-hot, one-cycle completion pulse to the owner.
- replacerEnable  out  1  one-cycle start strobe to the replacer.
- replacerCommand  out  ReplaceLogicCommand  latched command.
- replacerAddr  out  MEM_ADDR_WIDTH  latched address. Stable from Issue through done.
- replacerDone  in  1  replacer completion, single cycle.
- busy  out  1  high in any state other than Idle.
- illegalCommand  out  1  sticky. Set by an unsupported command. Cleared only by reset.

## Operation
- States: Idle, Issue, Wait, Reject.
- **Idle**
  - If no reqValid bit is set, stay in Idle.
  - Otherwise pick the first valid requester at or after rrPtr, wrapping mod N_REQ.
  - Latch the winner's index, command and address.
  - Legal command (WriteThrough, Replace or Invalidate): go to Issue.
  - Any other encoding: go to Reject.
- **Issue**
  - Assert replacerEnable for exactly one cycle.
  - Go to Wait.
- **Wait**
  - Hold until replacerDone.
  - In the cycle replacerDone is seen: reqDone[owner] = 1 (combinational from replacerDone), rrPtr <= (owner + 1) mod N_REQ, go to Idle.
- **Reject**
  - reqDone[owner] = 1 and illegalCommand <= 1.
  - rrPtr advances as in Wait.
  - Go to Idle. The replacer is never enabled.
- reqGrant[owner] is high in Issue, Wait and Reject.
- replacerCommand and replacerAddr always drive the latched registers. Live reqAddr and reqCommand are never forwarded.
- Deasserting reqValid[owner] mid-operation is ignored: the operation completes and reqDone still pulses.
- A requester still valid in the cycle after its reqDone is treated as a new request.
- A change to reqAddr or reqCommand of any requester while the replacer is busy has no effect until the next arbitration.

## Timing
- Reset values: state = Idle, rrPtr = 0, all latches 0. Outputs reqGrant, reqDone, replacerEnable, busy and illegalCommand are all 0.
- Reset mid-operation aborts to Idle with no reqDone. The replacer is reset by the same reset.
- Cycle numbering for a request first seen in Idle at cycle T:
  - T+1: Issue, replacerEnable = 1.
  - T+2 onward: Wait.
- Invalidate: the replacer signals done at T+2, so reqDone is at T+2 and Idle is at T+3.
- Replace: reqDone is at T+4+k, where k is the memory read latency in cycles.
- Reject path: reqDone at T+1.
- Minimum gap between replacerEnable strobes is 3 cycles. The replacer is back in its idle state in the cycle after it signals done, which is the cycle the arbiter re-enters Idle.
- replacerDone outside Wait is ignored.
- Fairness: after serving requester i, i has lowest priority, so each valid requester is served within N_REQ grants.
- All requesters valid at once: served i = rrPtr, rrPtr+1, … in order.

## Structure
- ReplaceLogicCommand already lives in CacheTypes.
- Add ReplaceArbiterState (Idle/Issue/Wait/Reject) to CacheTypes so trace and debug tooling can decode it.
- Sub-module dcache_rr_picker:
  - Combinational.
  - Inputs: reqValid and rrPtr. Outputs: winner index and an any-valid flag.
  - Implemented as a doubled-vector priority search.
- Remaining RTL: state register, latches, rrPtr and output decode.

## Test plan
- Single Invalidate: requester 0, address 0x0000123, replacer model signals done 1 cycle after enable. Expect replacerEnable at T+1, replacerAddr = 0x0000123 from T+1 through done, reqDone = 3'b001 at T+2, busy low at T+3.
- Round-robin: all three requesters valid continuously with Replace commands, replacer done 5 cycles after enable. Expect grant order 0, 1, 2, 0, and rrPtr wraps from 2 to 0.
- Address stability: requester 1 issues WriteThrough at 0x1, then changes reqAddr to 0x2 during Wait. Expect replacerAddr to stay 0x1 until done, and reqDone = 3'b010.
- Illegal command: requester 2 presents an unsupported encoding. Expect reqDone = 3'b100 at T+1, replacerEnable never high, illegalCommand high and sticky. The next valid request is served normally.
- Reset mid-Wait: drive rst low during Wait. Expect all outputs 0 next cycle, no reqDone, rrPtr = 0. A spurious replacerDone after reset is ignored.
- Drop-valid: requester 0 deasserts reqValid during Wait. Expect reqDone[0] still pulsed when done arrives, and no second grant to requester 0.
